ballot_input_ctrl: RTL and testbench

Upstream front end of `voting_machine`. It takes raw candidate push-buttons and a presiding-officer arm pulse, synchronises and debounces the buttons, and enforces one vote per armed ballot. Each accepted vote becomes a single-cycle pulse on exactly one of `o_BJP`, `o_INC`, `o_JDS`. These outputs connect directly to `voting_machine` `i_BJP`, `i_INC` and `i_JDS`.

---
 rtl/ballot_pkg.sv | 26 ++
 rtl/ballot_input_ctrl_button_debounce.sv | 51 +++++
 rtl/ballot_input_ctrl.sv | 129 ++++++++++++
 tb/tb_ballot_input_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ballot_pkg.sv
// Shared constants and types for the ballot input front end.
package ballot_pkg;

    localparam int NUM_CAND = 3;

    localparam int CAND_BJP = 0;
    localparam int CAND_INC = 1;
    localparam int CAND_JDS = 2;

    localparam int          BALLOT_W   = 6;
    localparam logic [5:0]  BALLOT_MAX = 6'd63;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAST,
        LOCKOUT,
        CLOSED
    } ballot_state_t;

    // Number of set bits in a candidate vector.
    function automatic logic [1:0] popcount3(input logic [NUM_CAND-1:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/ballot_input_ctrl_button_debounce.sv
// One push-button path: two-flop synchroniser, debounce counter and a
// registered rising-edge detector on the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, press_q;
    logic [CW-1:0] cnt_q;
    logic          differ, flip;

    assign differ = (sync2_q != level_q);
    // The counter would reach DEBOUNCE_CYCLES on this edge: flip instead of
    // storing that value, so the counter never needs to hold it.
    assign flip   = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    // Synchronise, count disagreement cycles, flip level and flag rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= flip && !level_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (flip) begin
                level_q <= !level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/ballot_input_ctrl.sv
// Ballot front end: debounced candidate buttons feed a one-vote-per-arm FSM
// that emits single-cycle vote pulses and counts accepted ballots.
module ballot_input_ctrl
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_btn_BJP,
    input  logic                i_btn_INC,
    input  logic                i_btn_JDS,
    input  logic                i_enable,
    input  logic                i_voting_over,
    output logic                o_BJP,
    output logic                o_INC,
    output logic                o_JDS,
    output logic                o_ready,
    output logic                o_reject,
    output logic [BALLOT_W-1:0] o_ballots
);

    localparam int LW = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

    logic [NUM_CAND-1:0] btn_raw, level, press;
    logic [NUM_CAND-1:0] other_high;
    logic                accept, reject_ev, lock_done;

    ballot_state_t       state_q;
    logic [NUM_CAND-1:0] vote_q;
    logic                ready_q, reject_q;
    logic [BALLOT_W-1:0] ballots_q;
    logic [LW-1:0]       lock_cnt_q;

    assign btn_raw = {i_btn_JDS, i_btn_INC, i_btn_BJP};

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn_i (btn_raw[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

    // A press is tainted when any other candidate's debounced level is high.
    always_comb begin
        other_high = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            other_high[i] = press[i] && |(level & ~(NUM_CAND'(1) << i));
        end
    end

    assign accept    = (popcount3(press) == 2'd1) && !(|other_high);
    assign reject_ev = (|press) && !accept;
    assign lock_done = (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1));

    // Ballot FSM with registered outputs; end-of-poll overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vote_q     <= '0;
            ready_q    <= 1'b0;
            reject_q   <= 1'b0;
            ballots_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            vote_q   <= '0;
            reject_q <= 1'b0;
            if (i_voting_over) begin
                state_q <= CLOSED;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_enable) begin
                            state_q <= ARMED;
                            ready_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (accept) begin
                            // The one-hot press vector is the latched candidate.
                            state_q <= CAST;
                            vote_q  <= press;
                            ready_q <= 1'b0;
                            if (ballots_q != BALLOT_MAX) begin
                                ballots_q <= ballots_q + BALLOT_W'(1);
                            end
                        end else if (reject_ev) begin
                            reject_q <= 1'b1;
                        end
                    end
                    CAST: begin
                        state_q    <= LOCKOUT;
                        lock_cnt_q <= '0;
                    end
                    LOCKOUT: begin
                        // Saturate the count, then wait for every button to be released.
                        if (!lock_done) begin
                            lock_cnt_q <= lock_cnt_q + LW'(1);
                        end else if (!(|level)) begin
                            state_q <= IDLE;
                        end
                    end
                    CLOSED: begin
                        state_q <= CLOSED;
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_BJP     = vote_q[CAND_BJP];
    assign o_INC     = vote_q[CAND_INC];
    assign o_JDS     = vote_q[CAND_JDS];
    assign o_ready   = ready_q;
    assign o_reject  = reject_q;
    assign o_ballots = ballots_q;

endmodule

// File: tb/tb_ballot_input_ctrl.sv
// Bench for ballot_input_ctrl: vector table plus hand sequences, with a
// scoreboard queue of expected vote pulses checked by a negedge monitor.
module tb_ballot_input_ctrl;

    localparam int DB  = 4;
    localparam int LO  = 8;
    localparam int LAT = 3 + DB;  // negedge-sample delay from raw drive to vote pulse

    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn_BJP, i_btn_INC, i_btn_JDS;
    logic       i_enable, i_voting_over;
    logic       o_BJP, o_INC, o_JDS, o_ready, o_reject;
    logic [5:0] o_ballots;

    ballot_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_BJP     (i_btn_BJP),
        .i_btn_INC     (i_btn_INC),
        .i_btn_JDS     (i_btn_JDS),
        .i_enable      (i_enable),
        .i_voting_over (i_voting_over),
        .o_BJP         (o_BJP),
        .o_INC         (o_INC),
        .o_JDS         (o_JDS),
        .o_ready       (o_ready),
        .o_reject      (o_reject),
        .o_ballots     (o_ballots)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cand;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [2:0] btn;   // {JDS, INC, BJP}
        logic       vote;
        int         rej;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   checks = 0, errors = 0, cyc = 0, rej_seen = 0;
    int   exp_b = 0, r0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [2:0] b);
        {i_btn_JDS, i_btn_INC, i_btn_BJP} = b;
    endtask

    task automatic arm();
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
    endtask

    task automatic push_vote(input logic [2:0] c);
        exp_t e;
        e.cand = c;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
        if (exp_b < 63) exp_b++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every vote pulse must match the head of the scoreboard, in content and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_reject) rej_seen++;
            if ({o_JDS, o_INC, o_BJP} != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vote", int'({o_JDS, o_INC, o_BJP}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("vote_cand", int'({o_JDS, o_INC, o_BJP}), int'(mon_e.cand));
                    chk("vote_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b010, 1'b1, 0};
        vecs[1] = '{3'b001, 1'b1, 0};
        vecs[2] = '{3'b100, 1'b1, 0};
        vecs[3] = '{3'b101, 1'b0, 1};
        vecs[4] = '{3'b011, 1'b0, 1};
        vecs[5] = '{3'b111, 1'b0, 1};
        vecs[6] = '{3'b010, 1'b1, 0};

        rst = 1'b1; i_enable = 1'b0; i_voting_over = 1'b0;
        set_btn(3'b000);
        step(3);
        chk("rst_BJP", int'(o_BJP), 0);
        chk("rst_INC", int'(o_INC), 0);
        chk("rst_JDS", int'(o_JDS), 0);
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_reject", int'(o_reject), 0);
        chk("rst_ballots", int'(o_ballots), 0);
        rst = 1'b0;
        step(2);

        // Table: arm, drive a button pattern, check reject/ready/count.
        for (int i = 0; i < 7; i++) begin
            arm();
            chk("ready_armed", int'(o_ready), 1);
            r0 = rej_seen;
            set_btn(vecs[i].btn);
            if (vecs[i].vote) push_vote(vecs[i].btn);
            step(10);
            chk("reject_cnt", rej_seen - r0, vecs[i].rej);
            chk("ready_after", int'(o_ready), vecs[i].vote ? 0 : 1);
            chk("ballots", int'(o_ballots), exp_b);
            set_btn(3'b000);
            step(20);
            chk("sb_drained", exp_q.size(), 0);
        end

        // BJP held before arming gives no vote; a fresh INC press while it is held is refused.
        set_btn(3'b001);
        step(10);
        arm();
        chk("held_ready", int'(o_ready), 1);
        step(3);
        r0 = rej_seen;
        set_btn(3'b011);
        step(10);
        chk("held_reject", rej_seen - r0, 1);
        chk("held_ready_stays", int'(o_ready), 1);
        set_btn(3'b000);
        step(10);
        set_btn(3'b010);
        push_vote(3'b010);
        step(10);
        set_btn(3'b000);
        step(20);
        chk("held_ballots", int'(o_ballots), exp_b);

        // Bouncing BJP: no pulse during bounce, one pulse once stable.
        arm();
        for (int k = 0; k < 5; k++) begin
            set_btn(3'b001); step(1);
            set_btn(3'b000); step(1);
        end
        set_btn(3'b001);
        push_vote(3'b001);
        step(10);
        set_btn(3'b000);
        step(20);
        chk("bounce_ballots", int'(o_ballots), exp_b);

        // Hold through lockout, then re-press without arming: nothing.
        arm();
        set_btn(3'b010);
        push_vote(3'b010);
        step(30);
        chk("lock_ready", int'(o_ready), 0);
        set_btn(3'b000);
        step(10);
        set_btn(3'b010);
        step(15);
        chk("lock_ballots", int'(o_ballots), exp_b);
        set_btn(3'b000);
        step(10);

        // Mid-operation reset clears the armed ballot and count.
        arm();
        chk("pre_rst_ready", int'(o_ready), 1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_ready", int'(o_ready), 0);
        chk("mid_rst_ballots", int'(o_ballots), 0);
        rst = 1'b0;
        exp_b = 0;
        step(2);

        // End of poll on the same edge as a valid press: no vote, then closed.
        arm();
        set_btn(3'b100);
        step(2 + DB);
        i_voting_over = 1'b1;
        step(1);
        i_voting_over = 1'b0;
        chk("closed_ready", int'(o_ready), 0);
        step(5);
        set_btn(3'b000);
        step(10);
        arm();
        chk("closed_arm_ready", int'(o_ready), 0);
        r0 = rej_seen;
        set_btn(3'b001);
        step(12);
        chk("closed_ballots", int'(o_ballots), 0);
        chk("closed_reject", rej_seen - r0, 0);
        set_btn(3'b000);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        exp_b = 0;
        step(2);

        // Saturation: 64 votes, count sticks at 63, 64th pulse still sent.
        for (int i = 0; i < 64; i++) begin
            arm();
            set_btn(3'b001);
            push_vote(3'b001);
            step(8);
            set_btn(3'b000);
            step(14);
            if (i == 62) chk("ballots_63", int'(o_ballots), 63);
            if (i == 63) chk("ballots_hold", int'(o_ballots), 63);
        end
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
